hazard_control_unit: RTL and testbench

//  Drives the hold/flush side of the ID/EX interface: decides each cycle whether ID/EX captures,

---
 rtl/hazard_control_unit_pkg.sv | 49 ++++
 rtl/hazard_control_unit_sat_counter.sv | 26 ++
 rtl/hazard_control_unit.sv | 110 +++++++++++
 tb/tb_hazard_control_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings for the hazard control unit: FSM states, control bundle, NOP word.
package hazard_control_unit_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_FREEZE   = 2'd2;

  // Instruction IF/ID loads when flushed (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_freeze;
  } hz_ctrl_t;

  function automatic hz_ctrl_t ctrl_idle();
    hz_ctrl_t c;
    c = '0;
    c.pc_write    = 1'b1;
    c.if_id_write = 1'b1;
    return c;
  endfunction

  function automatic hz_ctrl_t ctrl_stall();
    hz_ctrl_t c;
    c = '0;
    c.id_ex_bubble = 1'b1;
    return c;
  endfunction

  function automatic hz_ctrl_t ctrl_flush();
    hz_ctrl_t c;
    c = ctrl_idle();
    c.if_id_flush  = 1'b1;
    c.id_ex_bubble = 1'b1;
    return c;
  endfunction

  function automatic hz_ctrl_t ctrl_freeze();
    hz_ctrl_t c;
    c = '0;
    c.pipe_freeze = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!clr_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// ID/EX hold/flush control: load-use stalls, taken-beq flushes, dmem-wait freezes,
// plus saturating stall/flush statistics.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int LU_STALL_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_beq,
  input  logic             ex_zero,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [1:0] state_q, state_d;
  logic [1:0] saved_q, saved_d;
  logic [1:0] rem_q, rem_d;
  logic [1:0] eff_st;
  logic       lu_hit, br_take;
  logic       stall_inc, flush_inc;
  hz_ctrl_t   ctrl;

  assign lu_hit  = ex_mem_read && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign br_take = ex_beq && ex_zero;

  // While frozen, decisions are made as if in the state we froze from, so the
  // cycle dmem_ready returns already resumes the interrupted behaviour.
  assign eff_st = (state_q == ST_FREEZE) ? saved_q : state_q;

  always_comb begin
    ctrl      = ctrl_idle();
    state_d   = eff_st;
    saved_d   = saved_q;
    rem_d     = rem_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!reset) begin
      state_d = ST_RUN;
    end else if (!dmem_ready) begin
      ctrl    = ctrl_freeze();
      state_d = ST_FREEZE;
      saved_d = eff_st;
    end else if (br_take) begin
      // Any stalled instruction in ID is on the wrong path; drop the stall.
      ctrl      = ctrl_flush();
      flush_inc = 1'b1;
      state_d   = ST_RUN;
      rem_d     = 2'd0;
    end else if (eff_st == ST_LU_STALL) begin
      ctrl      = ctrl_stall();
      stall_inc = 1'b1;
      rem_d     = rem_q - 2'd1;
      state_d   = (rem_q == 2'd1) ? ST_RUN : ST_LU_STALL;
    end else if (lu_hit) begin
      ctrl      = ctrl_stall();
      stall_inc = 1'b1;
      if (LU_STALL_CYC > 1) begin
        state_d = ST_LU_STALL;
        rem_d   = 2'(LU_STALL_CYC - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      rem_q   <= rem_d;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign pipe_freeze  = ctrl.pipe_freeze;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clr_n_i (reset),
    .inc_i   (stall_inc),
    .cnt_o   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .clr_n_i (reset),
    .inc_i   (flush_inc),
    .cnt_o   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: three parameterizations driven with shared stimulus,
// each checked every cycle against a bubble-count reference model.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       uses2, mr, beq, zero, ready;

  wire  [4:0]  c [3];
  wire  [15:0] s1, f1, s2, f2;
  wire  [3:0]  s3, f3;

  int checks = 0;
  int errors = 0;

  int ncyc [3] = '{1, 2, 1};
  int cmax [3] = '{65535, 65535, 15};
  int left [3];
  int sc   [3];
  int fc   [3];

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(16), .LU_STALL_CYC(1)) dut1 (
    .clk(clk), .reset(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(uses2),
    .ex_mem_read(mr), .ex_rd(rd), .ex_beq(beq), .ex_zero(zero), .dmem_ready(ready),
    .pc_write(c[0][4]), .if_id_write(c[0][3]), .if_id_flush(c[0][2]),
    .id_ex_bubble(c[0][1]), .pipe_freeze(c[0][0]), .stall_cnt(s1), .flush_cnt(f1));

  hazard_control_unit #(.CNT_W(16), .LU_STALL_CYC(2)) dut2 (
    .clk(clk), .reset(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(uses2),
    .ex_mem_read(mr), .ex_rd(rd), .ex_beq(beq), .ex_zero(zero), .dmem_ready(ready),
    .pc_write(c[1][4]), .if_id_write(c[1][3]), .if_id_flush(c[1][2]),
    .id_ex_bubble(c[1][1]), .pipe_freeze(c[1][0]), .stall_cnt(s2), .flush_cnt(f2));

  hazard_control_unit #(.CNT_W(4), .LU_STALL_CYC(1)) dut3 (
    .clk(clk), .reset(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(uses2),
    .ex_mem_read(mr), .ex_rd(rd), .ex_beq(beq), .ex_zero(zero), .dmem_ready(ready),
    .pc_write(c[2][4]), .if_id_write(c[2][3]), .if_id_flush(c[2][2]),
    .id_ex_bubble(c[2][1]), .pipe_freeze(c[2][0]), .stall_cnt(s3), .flush_cnt(f3));

  // exp bits: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
  typedef struct {
    logic       r;
    logic [4:0] a, b;
    logic       u, m;
    logic [4:0] d;
    logic       bq, z, rdy;
    logic [4:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] a, input logic [4:0] b, input logic u,
                       input logic m, input logic [4:0] d, input logic bq, input logic z,
                       input logic rdy);
    rst = r; rs1 = a; rs2 = b; uses2 = u; mr = m; rd = d; beq = bq; zero = z; ready = rdy;
  endtask

  function automatic logic lu_now();
    return mr && (rd != 0) && ((rd == rs1) || (uses2 && (rd == rs2)));
  endfunction

  function automatic logic [4:0] mexp(input int i);
    if (!rst)                      return 5'b11000;
    if (!ready)                    return 5'b00001;
    if (beq && zero)               return 5'b11110;
    if (left[i] > 0 || lu_now())   return 5'b00010;
    return 5'b11000;
  endfunction

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic mupdate();
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        left[i] = 0; sc[i] = 0; fc[i] = 0;
      end else if (!ready) begin
        // frozen: nothing moves
      end else if (beq && zero) begin
        fc[i] = sat_inc(fc[i], cmax[i]); left[i] = 0;
      end else if (left[i] > 0) begin
        sc[i] = sat_inc(sc[i], cmax[i]); left[i]--;
      end else if (lu_now()) begin
        sc[i] = sat_inc(sc[i], cmax[i]); left[i] = ncyc[i] - 1;
      end
    end
  endtask

  // Sample at negedge and compare all three DUTs with the model
  task automatic settle();
    @(negedge clk);
    chk("ctrl1", {27'd0, c[0]}, {27'd0, mexp(0)});
    chk("ctrl2", {27'd0, c[1]}, {27'd0, mexp(1)});
    chk("ctrl3", {27'd0, c[2]}, {27'd0, mexp(2)});
    chk("stall1", {16'd0, s1}, sc[0]);
    chk("flush1", {16'd0, f1}, fc[0]);
    chk("stall2", {16'd0, s2}, sc[1]);
    chk("flush2", {16'd0, f2}, fc[1]);
    chk("stall3", {28'd0, s3}, sc[2]);
    chk("flush3", {28'd0, f3}, fc[2]);
  endtask

  task automatic advance();
    @(posedge clk);
    mupdate();
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  vec_t vecs [11];
  int   nb, nf;

  initial begin
    vecs[0]  = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 5'b00010};
    vecs[1]  = '{1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 5'b11000};
    vecs[2]  = '{1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 5'b00010};
    vecs[3]  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11000};
    vecs[4]  = '{1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 5'b11110};
    vecs[5]  = '{1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 5'b11000};
    vecs[6]  = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'b11110};
    vecs[7]  = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'b00001};
    vecs[8]  = '{1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 5'b00001};
    vecs[9]  = '{1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 5'b11000};
    vecs[10] = '{1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 5'b11000};

    // Reset; model starts from cleared state
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin left[i] = 0; sc[i] = 0; fc[i] = 0; end
    step();
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 1);
    step();

    // Table vectors (expected values target the single-bubble instance)
    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].a, vecs[k].b, vecs[k].u, vecs[k].m, vecs[k].d,
            vecs[k].bq, vecs[k].z, vecs[k].rdy);
      settle();
      chk($sformatf("vec%0d", k), {27'd0, c[0]}, {27'd0, vecs[k].exp});
      advance();
    end

    // Two-bubble hazard interrupted by a 3-cycle memory wait
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    drive(1'b1, 5'd5, 0, 0, 1, 5'd5, 0, 0, 1);
    nb = 0; nf = 0;
    settle(); nb += c[1][1]; advance();
    drive(1'b1, 5'd5, 0, 0, 0, 5'd0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin settle(); nf += c[1][0]; nb += c[1][1]; advance(); end
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin settle(); nf += c[1][0]; nb += c[1][1]; advance(); end
    chk("t4_bubbles", nb, 2);
    chk("t4_freezes", nf, 3);
    chk("t4_stall_cnt", {16'd0, s2}, 2);

    // Saturation on the 4-bit instance
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    drive(1'b1, 5'd5, 0, 0, 1, 5'd5, 0, 0, 1);
    for (int k = 0; k < 20; k++) step();
    settle();
    chk("t6_sat", {28'd0, s3}, 15);
    advance();

    // Reset in the middle of a two-bubble stall
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 1); step(); step();
    drive(1'b1, 5'd5, 0, 0, 1, 5'd5, 0, 0, 1); step();
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    chk("t6_rst_ctrl", {27'd0, c[1]}, 32'h18);
    advance();
    rst = 1'b1;
    settle();
    chk("t6_run_after_rst", {27'd0, c[1]}, 32'h18);
    chk("t6_cnt_cleared", {s2, f2}, 0);
    advance();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 49) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 6) != 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
